pixel_framer: RTL

Upstream stage of the `cluster` centroid block. It converts the raw camera stream into the coordinate-tagged pixel stream that `cluster` consumes:
- input is frame-valid/line-valid qualified, 12-bit unsigned RGB;
- output is 12-bit signed RGB with `pixel_valid` and raster `x`/`y`.

It also flags malformed lines and frames, and emits a frame-end pulse only for complete frames.

---
 rtl/pixel_pkg.sv | 38 +++
 rtl/pixel_framer_edge_det.sv | 32 +++
 rtl/pixel_framer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// ---------------------------------------------------------------------------
// pixel_pkg
// Shared definitions for the camera-to-cluster pixel path: sample width,
// signed saturation limit, framer state encoding, the RGB payload struct and
// the unsigned-to-signed saturating converter.
// ---------------------------------------------------------------------------
package pixel_pkg;

    localparam int unsigned PIX_W = 12;

    localparam logic signed [PIX_W-1:0] PIX_SMAX = 12'sd2047;

    typedef enum logic [1:0] {
        WAIT_GAP,
        IDLE,
        ACTIVE
    } framer_state_t;

    // One signed RGB sample as handed to the cluster stage.
    typedef struct packed {
        logic signed [PIX_W-1:0] r;
        logic signed [PIX_W-1:0] g;
        logic signed [PIX_W-1:0] b;
    } rgb_t;

    // Clamp an unsigned sample into the positive half of the signed range.
    // Values that fit are reinterpreted bit-for-bit, so bit 11 is always 0.
    function automatic logic signed [PIX_W-1:0] sat_u2s(input logic [PIX_W-1:0] v);
        logic signed [PIX_W-1:0] res;
        if (v[PIX_W-1]) begin
            res = PIX_SMAX;
        end else begin
            res = $signed(v);
        end
        return res;
    endfunction

endpackage

// File: rtl/pixel_framer_edge_det.sv
// ---------------------------------------------------------------------------
// edge_det
// Registers a level input and reports its rising and falling edges against
// the registered copy.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : level input
//   q          : d delayed by one clock (registered)
//   rise_c     : d high now, low last cycle (combinational)
//   fall_c     : d low now, high last cycle (combinational)
// ---------------------------------------------------------------------------
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    // Previous-cycle copy of the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign rise_c = d & ~q;
    assign fall_c = ~d & q;

endmodule

// File: rtl/pixel_framer.sv
// ---------------------------------------------------------------------------
// pixel_framer
// Turns the fval/lval-qualified unsigned camera stream into a saturated
// signed RGB stream tagged with raster x/y. Malformed lines and frames are
// flagged, and frame_end fires only for a complete, error-free frame.
//   clk, rst_n              : clock, asynchronous active-low reset
//   fval, lval              : camera frame / line valid
//   in_r, in_g, in_b        : unsigned camera samples
//   pixel_r/g/b             : saturated signed samples (registered)
//   pixel_valid             : output pixel qualifier (registered)
//   x, y                    : raster position of the output pixel (registered)
//   frame_start, frame_end  : one-cycle frame pulses (registered)
//   line_err, frame_err     : sticky error flags, cleared at frame_start
// ---------------------------------------------------------------------------
module pixel_framer
    import pixel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            fval,
    input  logic                            lval,
    input  logic [11:0]                     in_r,
    input  logic [11:0]                     in_g,
    input  logic [11:0]                     in_b,
    output logic signed [11:0]              pixel_r,
    output logic signed [11:0]              pixel_g,
    output logic signed [11:0]              pixel_b,
    output logic                            pixel_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]    x,
    output logic [$clog2(IMG_HEIGHT)-1:0]   y,
    output logic                            frame_start,
    output logic                            frame_end,
    output logic                            line_err,
    output logic                            frame_err
);

    // Counters need one extra code so they can sit at "full" (WIDTH/HEIGHT).
    localparam int unsigned XCW = $clog2(IMG_WIDTH + 1);
    localparam int unsigned YCW = $clog2(IMG_HEIGHT + 1);
    localparam int unsigned XW  = $clog2(IMG_WIDTH);
    localparam int unsigned YW  = $clog2(IMG_HEIGHT);

    localparam logic [XCW-1:0] X_FULL = XCW'(IMG_WIDTH);
    localparam logic [YCW-1:0] Y_FULL = YCW'(IMG_HEIGHT);

    framer_state_t  state;
    framer_state_t  state_nxt;

    logic           fval_q;
    logic           fval_rise;
    logic           fval_fall;
    logic           lval_d;
    logic           lval_rise;
    logic           lval_fall;

    logic [XCW-1:0] x_cnt;
    logic [XCW-1:0] x_cnt_nxt;
    logic [YCW-1:0] y_cnt;
    logic [YCW-1:0] y_cnt_nxt;

    rgb_t           pix_nxt;
    logic [XW-1:0]  x_nxt;
    logic [YW-1:0]  y_nxt;
    logic           valid_nxt;
    logic           start_nxt;
    logic           end_nxt;
    logic           line_err_nxt;
    logic           frame_err_nxt;

    logic           pix_in;
    logic           line_close;

    // Frame and line edge detection.
    edge_det u_fval_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (fval),
        .q      (fval_q),
        .rise_c (fval_rise),
        .fall_c (fval_fall)
    );

    edge_det u_lval_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (lval),
        .q      (lval_d),
        .rise_c (lval_rise),
        .fall_c (lval_fall)
    );

    // The registered fval copy and lval rise are not needed by the framer.
    logic unused_edges;
    assign unused_edges = fval_q ^ lval_rise;

    assign pix_in = fval & lval;

    // A line also closes when fval drops while lval is still high.
    assign line_close = lval_fall | (lval_d & ~fval);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_GAP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. In IDLE fval was low last cycle, and in ACTIVE it was
    // high, so the edge pulses coincide with the sampled levels there.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_GAP: begin
                if (!fval) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (fval_rise) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (fval_fall) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = WAIT_GAP;
            end
        endcase
    end

    // Output / datapath next-value logic.
    always_comb begin
        x_cnt_nxt     = x_cnt;
        y_cnt_nxt     = y_cnt;
        pix_nxt.r     = pixel_r;
        pix_nxt.g     = pixel_g;
        pix_nxt.b     = pixel_b;
        x_nxt         = x;
        y_nxt         = y;
        valid_nxt     = 1'b0;
        start_nxt     = 1'b0;
        end_nxt       = 1'b0;
        line_err_nxt  = line_err;
        frame_err_nxt = frame_err;

        case (state)
            IDLE: begin
                if (fval_rise) begin
                    start_nxt     = 1'b1;
                    line_err_nxt  = 1'b0;
                    frame_err_nxt = 1'b0;
                    x_cnt_nxt     = '0;
                    y_cnt_nxt     = '0;
                    // lval already high on the opening sample: first pixel.
                    if (lval) begin
                        valid_nxt = 1'b1;
                        pix_nxt.r = sat_u2s(in_r);
                        pix_nxt.g = sat_u2s(in_g);
                        pix_nxt.b = sat_u2s(in_b);
                        x_nxt     = '0;
                        y_nxt     = '0;
                        x_cnt_nxt = XCW'(1);
                    end
                end
            end
            ACTIVE: begin
                // Pixel and line close are mutually exclusive in one sample.
                if (pix_in) begin
                    if (y_cnt >= Y_FULL) begin
                        frame_err_nxt = 1'b1;
                    end else if (x_cnt < X_FULL) begin
                        valid_nxt = 1'b1;
                        pix_nxt.r = sat_u2s(in_r);
                        pix_nxt.g = sat_u2s(in_g);
                        pix_nxt.b = sat_u2s(in_b);
                        x_nxt     = XW'(x_cnt);
                        y_nxt     = YW'(y_cnt);
                        x_cnt_nxt = x_cnt + XCW'(1);
                    end else begin
                        line_err_nxt = 1'b1;
                    end
                end

                if (line_close) begin
                    if (x_cnt != X_FULL) begin
                        line_err_nxt = 1'b1;
                    end
                    x_cnt_nxt = '0;
                    if (y_cnt != Y_FULL) begin
                        y_cnt_nxt = y_cnt + YCW'(1);
                    end
                end

                // Frame close sees the result of a same-cycle line close.
                if (fval_fall) begin
                    if ((y_cnt_nxt == Y_FULL) && !line_err_nxt) begin
                        end_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            pixel_r     <= '0;
            pixel_g     <= '0;
            pixel_b     <= '0;
            pixel_valid <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            x_cnt       <= x_cnt_nxt;
            y_cnt       <= y_cnt_nxt;
            pixel_r     <= pix_nxt.r;
            pixel_g     <= pix_nxt.g;
            pixel_b     <= pix_nxt.b;
            pixel_valid <= valid_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            frame_start <= start_nxt;
            frame_end   <= end_nxt;
            line_err    <= line_err_nxt;
            frame_err   <= frame_err_nxt;
        end
    end

endmodule
